// File: rtl/multi_cycle_control_pkg.sv
// Shared constants for the RV32I multi-cycle control path: ALU op codes,
// base opcodes, FSM state encoding and the datapath control bundle.
package multi_cycle_control_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_BEQ = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_BNE = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_BLT = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_BGE = 4'd10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRC_B_REG  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] WR_ALUOUT = 2'd0;
    localparam logic [1:0] WR_MDR    = 2'd1;
    localparam logic [1:0] WR_ALU    = 2'd2;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_R, S_EX_I, S_EX_MA, S_MEM_RD, S_WB_LD, S_MEM_WR,
        S_WB_ALU, S_EX_BR, S_BR_NT, S_EX_JAL, S_EX_JALR, S_WB_JALR, S_HALT
    } state_t;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] wr_data_sel;
        logic       pc_write;
        logic       pc_source;
        logic       halted;
    } ctrl_t;

    // Sequential PC update: PC <= PC + 4 through the live ALU result.
    function automatic ctrl_t pc_plus4(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.alu_src_a = 1'b0;
        r.alu_src_b = SRC_B_FOUR;
        r.pc_source = 1'b0;
        r.pc_write  = 1'b1;
        return r;
    endfunction

    // Link-and-jump: rd <= PC + 4 (live ALU), PC <= target held in ALUOut.
    function automatic ctrl_t jump_link(input ctrl_t c);
        ctrl_t r;
        r             = c;
        r.alu_src_a   = 1'b0;
        r.alu_src_b   = SRC_B_FOUR;
        r.reg_write   = 1'b1;
        r.wr_data_sel = WR_ALU;
        r.pc_write    = 1'b1;
        r.pc_source   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/multi_cycle_control_alu_op_decode.sv
// ALU operation select from FSM state and instruction fields; ADD everywhere
// except the R/I execute and branch compare states.
module alu_op_decode
    import multi_cycle_control_pkg::*;
(
    input  state_t              state,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    output logic [ALU_OP_W-1:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (state == S_EX_R || state == S_EX_I) begin
            case (funct3)
                3'b000:  alu_op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                3'b111:  alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end else if (state == S_EX_BR) begin
            case (funct3)
                3'b001:  alu_op = ALU_BNE;
                3'b100:  alu_op = ALU_BLT;
                3'b101:  alu_op = ALU_BGE;
                default: alu_op = ALU_BEQ;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// RV32I multi-cycle control FSM (IF/ID/EX/MEM/WB). Optional build macro
// ILLEGAL_TRAP_EN halts on unknown opcodes and adds the illegal_inst output.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int unsigned ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             instruction,
    input  logic                    alu_bcond,
    input  logic                    mem_ready,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic                    i_or_d,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    reg_write,
    output logic [1:0]              wr_data_sel,
    output logic                    pc_write,
    output logic                    pc_source,
    output logic                    halted
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                    illegal_inst
`endif
);

    state_t              state;
    state_t              next_state;
    ctrl_t               ctrl;
    logic                known_op;
    logic [ALU_OP_W-1:0] dec_op;
    logic [6:0]          opcode;
    logic                unused_fields;

    assign opcode        = instruction[6:0];
    assign unused_fields = ^{instruction[31], instruction[29:15], instruction[11:7]};

    alu_op_decode u_alu_op_decode (
        .state    (state),
        .opcode   (opcode),
        .funct3   (instruction[14:12]),
        .funct7_5 (instruction[30]),
        .alu_op   (dec_op)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IF;
        else        state <= next_state;
    end

    // Next state and datapath controls; reset forces every control low at once.
    always_comb begin
        next_state = state;
        ctrl       = '0;
        known_op   = 1'b1;
        unique case (state)
            S_IF: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b0;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    next_state    = S_ID;
                end
            end
            S_ID: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R:               next_state = S_EX_R;
                    OP_I:               next_state = S_EX_I;
                    OP_LOAD, OP_STORE:  next_state = S_EX_MA;
                    OP_BRANCH:          next_state = S_EX_BR;
                    OP_JAL:             next_state = S_EX_JAL;
                    OP_JALR:            next_state = S_EX_JALR;
                    OP_SYSTEM:          next_state = S_HALT;
                    default: begin
                        known_op = 1'b0;
`ifdef ILLEGAL_TRAP_EN
                        next_state = S_HALT;
`else
                        next_state = S_BR_NT;
`endif
                    end
                endcase
            end
            S_EX_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                next_state     = S_WB_ALU;
            end
            S_EX_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                next_state     = S_WB_ALU;
            end
            S_WB_ALU: begin
                ctrl.reg_write   = 1'b1;
                ctrl.wr_data_sel = WR_ALUOUT;
                ctrl             = pc_plus4(ctrl);
                next_state       = S_IF;
            end
            S_EX_MA: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                next_state     = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready) next_state = S_WB_LD;
            end
            S_WB_LD: begin
                ctrl.reg_write   = 1'b1;
                ctrl.wr_data_sel = WR_MDR;
                ctrl             = pc_plus4(ctrl);
                next_state       = S_IF;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    ctrl       = pc_plus4(ctrl);
                    next_state = S_IF;
                end
            end
            S_EX_BR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                if (alu_bcond) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = 1'b1;
                    next_state     = S_IF;
                end else begin
                    next_state = S_BR_NT;
                end
            end
            S_BR_NT: begin
                ctrl       = pc_plus4(ctrl);
                next_state = S_IF;
            end
            S_EX_JAL: begin
                ctrl       = jump_link(ctrl);
                next_state = S_IF;
            end
            S_EX_JALR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                next_state     = S_WB_JALR;
            end
            S_WB_JALR: begin
                ctrl       = jump_link(ctrl);
                next_state = S_IF;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: next_state = S_IF;
        endcase
        if (!reset) ctrl = '0;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky record that the halt came from an undecodable opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          illegal_q <= 1'b0;
        else if (state == S_ID && !known_op) illegal_q <= 1'b1;
    end

    assign illegal_inst = illegal_q && reset;
`else
    logic unused_known;
    assign unused_known = known_op;
`endif

    assign alu_op      = reset ? ALU_OP_WIDTH'(dec_op) : ALU_OP_WIDTH'(ALU_ADD);
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign i_or_d      = ctrl.i_or_d;
    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;
    assign ir_write    = ctrl.ir_write;
    assign reg_write   = ctrl.reg_write;
    assign wr_data_sel = ctrl.wr_data_sel;
    assign pc_write    = ctrl.pc_write;
    assign pc_source   = ctrl.pc_source;
    assign halted      = ctrl.halted;

endmodule
